modulo_varredura_matriz: RTL and testbench

MODULO_VARREDURA_MATRIZ -- requirements
Module: modulo_varredura_matriz

---
 rtl/modulo_varredura_matriz_pkg.sv | 41 ++++
 rtl/modulo_varredura_matriz_prescaler.sv | 31 +++
 rtl/modulo_varredura_matriz.sv | 149 ++++++++++++++
 tb/tb_modulo_varredura_matriz.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/modulo_varredura_matriz_pkg.sv
// Shared definitions for the 5x7 matrix column scanner.
// Holds the matrix geometry, the scanner state encoding and the helpers that
// turn a stored image plus a column index into column-select / row data.
// Optional feature macro: BLANKING_EN adds the BLANK state to the encoding.
package modulo_varredura_matriz_pkg;

  localparam int unsigned NCOL  = 5;
  localparam int unsigned NROW  = 7;
  localparam int unsigned MAT_W = NCOL * NROW;
  localparam int unsigned COL_W = 3;
  localparam int unsigned PRE_W = 16;

  // All columns deselected (active-low select lines)
  localparam logic [NCOL-1:0] COL_OFF = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2
`ifdef BLANKING_EN
    ,
    ST_BLANK = 2'd3
`endif
  } state_t;

  // Active-low one-hot column select; column 0 drives the MSB
  function automatic logic [NCOL-1:0] col_sel(input logic [COL_W-1:0] col);
    logic [NCOL-1:0] onehot;
    onehot = {1'b1, {(NCOL-1){1'b0}}};
    return ~(onehot >> col);
  endfunction

  // Rows of one column: column c occupies m[34-7c : 28-7c], row 0 at the MSB
  function automatic logic [NROW-1:0] col_rows(input logic [MAT_W-1:0] frame,
                                               input logic [COL_W-1:0] col);
    int unsigned amt;
    amt = NROW * (NCOL - 1 - 32'(col));
    return NROW'(frame >> amt);
  endfunction

endpackage

// File: rtl/modulo_varredura_matriz_prescaler.sv
// modulo_prescaler: column dwell counter.
// Counts 0..DIV-1 while i_en is high and wraps to 0 after DIV-1.
// Ports: clk; i_clr sync clear (priority); i_en count enable;
//        o_tc_c combinational terminal count (high on the DIV-1 cycle while enabled).
module modulo_prescaler
  import modulo_varredura_matriz_pkg::*;
#(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] r_count;

  assign o_tc_c = i_en && (r_count == LAST);

  // Dwell counter with wrap at terminal count
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc_c ? '0 : r_count + PRE_W'(1);
    end
  end

endmodule

// File: rtl/modulo_varredura_matriz.sv
// modulo_varredura_matriz: 5x7 LED matrix column scanner.
// Snapshots the matrix image once per frame, then lights each column for DIV
// cycles. With BLANKING_EN defined, one all-off cycle separates consecutive
// columns of a frame to suppress ghosting.
// Ports: clk; clr sync active-high reset; m_in 35-bit image; en scan enable;
//        col_out active-low column select (col_out[4] = column 0);
//        row_out active-high rows (row_out[6] = row 0);
//        frame_done one-cycle pulse after the last column of a frame.
module modulo_varredura_matriz
  import modulo_varredura_matriz_pkg::*;
#(
  parameter int unsigned DIV = 1000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [MAT_W-1:0]  m_in,
  input  logic              en,
  output logic [NCOL-1:0]   col_out,
  output logic [NROW-1:0]   row_out,
  output logic              frame_done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOL - 1);

  state_t           r_state;
  logic [COL_W-1:0] r_col_idx;
  logic [MAT_W-1:0] r_frame;
  logic [NCOL-1:0]  r_col_out;
  logic [NROW-1:0]  r_row_out;
  logic             r_frame_done;

  state_t           w_state_nxt;
  logic [COL_W-1:0] w_col_idx_nxt;
  logic [MAT_W-1:0] w_frame_nxt;
  logic [NCOL-1:0]  w_col_out_nxt;
  logic [NROW-1:0]  w_row_out_nxt;
  logic             w_frame_done_nxt;

  logic             w_pre_en;
  logic             w_pre_clr;
  logic             w_tc;

  // The prescaler only runs in SCAN and sits at zero everywhere else
  assign w_pre_en  = (r_state == ST_SCAN);
  assign w_pre_clr = clr || !w_pre_en;

  modulo_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .i_clr  (w_pre_clr),
    .i_en   (w_pre_en),
    .o_tc_c (w_tc)
  );

  // State, frame snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= ST_IDLE;
      r_col_idx    <= '0;
      r_frame      <= '0;
      r_col_out    <= COL_OFF;
      r_row_out    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_col_idx    <= w_col_idx_nxt;
      r_frame      <= w_frame_nxt;
      r_col_out    <= w_col_out_nxt;
      r_row_out    <= w_row_out_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Next state; outputs are computed for the state being entered so that the
  // registered outputs line up with it (column 0 on the cycle after LOAD)
  always_comb begin
    w_state_nxt      = r_state;
    w_col_idx_nxt    = r_col_idx;
    w_frame_nxt      = r_frame;
    w_col_out_nxt    = COL_OFF;
    w_row_out_nxt    = '0;
    w_frame_done_nxt = 1'b0;

    if (!en) begin
      // Abandon any frame in progress without signalling completion
      w_state_nxt   = ST_IDLE;
      w_col_idx_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_LOAD;
        end

        ST_LOAD: begin
          w_frame_nxt   = m_in;
          w_col_idx_nxt = '0;
          w_state_nxt   = ST_SCAN;
          w_col_out_nxt = col_sel('0);
          w_row_out_nxt = col_rows(m_in, '0);
        end

        ST_SCAN: begin
          w_col_out_nxt = col_sel(r_col_idx);
          w_row_out_nxt = col_rows(r_frame, r_col_idx);
          if (w_tc) begin
            if (r_col_idx == LAST_COL) begin
              w_state_nxt      = ST_LOAD;
              w_col_idx_nxt    = '0;
              w_frame_done_nxt = 1'b1;
              w_col_out_nxt    = COL_OFF;
              w_row_out_nxt    = '0;
            end else begin
              w_col_idx_nxt = r_col_idx + COL_W'(1);
`ifdef BLANKING_EN
              w_state_nxt   = ST_BLANK;
              w_col_out_nxt = COL_OFF;
              w_row_out_nxt = '0;
`else
              w_state_nxt   = ST_SCAN;
              w_col_out_nxt = col_sel(r_col_idx + COL_W'(1));
              w_row_out_nxt = col_rows(r_frame, r_col_idx + COL_W'(1));
`endif
            end
          end
        end

`ifdef BLANKING_EN
        ST_BLANK: begin
          // Column index was already advanced on entry
          w_state_nxt   = ST_SCAN;
          w_col_out_nxt = col_sel(r_col_idx);
          w_row_out_nxt = col_rows(r_frame, r_col_idx);
        end
`endif

        default: begin
          w_state_nxt   = ST_IDLE;
          w_col_idx_nxt = '0;
        end
      endcase
    end
  end

  assign col_out    = r_col_out;
  assign row_out    = r_row_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// Self-checking bench for modulo_varredura_matriz (DIV=4), with or without BLANKING_EN.
module tb_modulo_varredura_matriz;

  localparam int unsigned DIV = 4;
`ifdef BLANKING_EN
  localparam int unsigned BL = 1;
`else
  localparam int unsigned BL = 0;
`endif
  localparam int unsigned PERIOD = 1 + 5 * DIV + 4 * BL;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic [34:0] m_in;
  logic [4:0]  col_out;
  logic [6:0]  row_out;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_act;
  int unsigned m_pos;
  logic [34:0] m_frame;
  logic [4:0]  e_col;
  logic [6:0]  e_row;
  logic        e_done;

  always #5 clk = ~clk;

  modulo_varredura_matriz #(
    .DIV (DIV)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .m_in       (m_in),
    .en         (en),
    .col_out    (col_out),
    .row_out    (row_out),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-position model: pos 0 is the snapshot cycle, then 5 columns of DIV
  // cycles each, with BL dark cycles between columns.
  task automatic model_edge();
    int unsigned k, c, w;
    e_col  = 5'b11111;
    e_row  = '0;
    e_done = 1'b0;
    if (clr) begin
      m_act   = 1'b0;
      m_frame = '0;
    end else if (!en) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      m_act = 1'b1;
      m_pos = 0;
    end else begin
      if (m_pos == 0) m_frame = m_in;
      m_pos++;
      if (m_pos == PERIOD) begin
        m_pos  = 0;
        e_done = 1'b1;
      end else begin
        k = m_pos - 1;
        c = k / (DIV + BL);
        w = k % (DIV + BL);
        if (w < DIV) begin
          e_col[4-c] = 1'b0;
          for (int r = 0; r < 7; r++) e_row[6-r] = m_frame[34-(7*c+r)];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("col_out", 35'(col_out), 35'(e_col));
    check("row_out", 35'(row_out), 35'(e_row));
    check("frame_done", 35'(frame_done), 35'(e_done));
  endtask

  task automatic rand_img(output logic [34:0] v);
    v = 35'({$urandom, $urandom});
  endtask

  initial begin
    int n;
    bit seen;
    logic [34:0] img;
    clr  = 1'b1;
    en   = 1'b1;
    rand_img(img);
    m_in = img;
    m_act = 1'b0; m_pos = 0; m_frame = '0;

    // Reset held with enable high
    step();
    step();

    // All-ones image: first frame_done lands PERIOD cycles after LOAD
    clr  = 1'b0;
    m_in = 35'h7_FFFF_FFFF;
    n = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      n++;
      seen = frame_done;
    end
    check("first_done_cycle", 35'(n - 1), 35'(PERIOD));

    // Single-pixel image, changed mid-frame to confirm the snapshot holds
    m_in = 35'h4_0000_0000;
    n = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      n++;
      if (n == 8) begin
        rand_img(img);
        m_in = img;
      end
      seen = frame_done;
    end
    check("frame_period", 35'(n), 35'(PERIOD));

    // Abort during column 2, then resume
    n = 0;
    while (e_col != 5'b11011 && n < 200) begin
      step();
      n++;
    end
    check("reach_col2", 35'(e_col), 35'(5'b11011));
    en = 1'b0;
    step();
    step();
    en = 1'b1;
    for (int i = 0; i < 2 * PERIOD; i++) step();

    // Mid-column and mid-frame reset
    for (int i = 0; i < 7; i++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < PERIOD; i++) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 5) == 0) begin
        rand_img(img);
        m_in = img;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
